// File: rtl/obi_arbiter_2to1.sv
// ---------------------------------------------------------------------------
// obi_arbiter_2to1
//
// Purpose:
//   Shares one secondary OBI port between two controllers (c0, c1).
//   - Round-robin arbitration on the address phase. The selection is locked
//     while the secondary port is stalling a request, so address-phase
//     signals stay stable until the grant arrives.
//   - Up to DEPTH accepted transactions may be outstanding. The issuing
//     controller of each one is kept in a 1-bit ID FIFO, and responses are
//     routed back in order.
//   - rsp_err_o is a sticky flag. It is set when a response arrives while
//     nothing is outstanding.
//
// Ports:
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   cK_req_i / cK_gnt_o           controller K address-phase handshake
//   cK_addr_i/we_i/be_i/wdata_i   controller K request payload
//   cK_rvalid_o / cK_rdata_o      controller K response
//   secondary_req_o / gnt_i       shared-port address-phase handshake
//   secondary_addr/we/be/wdata_o  payload muxed from the selected controller
//   secondary_rvalid_i / rdata_i  shared-port response
//   outstanding_o                 accepted transactions awaiting rvalid
//   rsp_err_o                     sticky unexpected-response flag
// ---------------------------------------------------------------------------
module obi_arbiter_2to1 #(
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,

  input  logic                       c0_req_i,
  output logic                       c0_gnt_o,
  input  logic [31:0]                c0_addr_i,
  input  logic                       c0_we_i,
  input  logic [3:0]                 c0_be_i,
  input  logic [31:0]                c0_wdata_i,
  output logic                       c0_rvalid_o,
  output logic [31:0]                c0_rdata_o,

  input  logic                       c1_req_i,
  output logic                       c1_gnt_o,
  input  logic [31:0]                c1_addr_i,
  input  logic                       c1_we_i,
  input  logic [3:0]                 c1_be_i,
  input  logic [31:0]                c1_wdata_i,
  output logic                       c1_rvalid_o,
  output logic [31:0]                c1_rdata_o,

  output logic                       secondary_req_o,
  input  logic                       secondary_gnt_i,
  output logic [31:0]                secondary_addr_o,
  output logic                       secondary_we_o,
  output logic [3:0]                 secondary_be_o,
  output logic [31:0]                secondary_wdata_o,
  input  logic                       secondary_rvalid_i,
  input  logic [31:0]                secondary_rdata_i,

  output logic [$clog2(DEPTH):0]     outstanding_o,
  output logic                       rsp_err_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // Arbitration state
  logic r_prio;
  logic r_lock;
  logic r_lock_sel;
  logic r_prio_next;
  logic r_lock_next;
  logic r_lock_sel_next;

  // ID FIFO state
  logic [DEPTH-1:0] r_fifo;
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [CW-1:0]    r_count_next;
  logic             r_rsp_err;

  logic w_full;
  logic w_sel;
  logic w_req_sel;
  logic w_push;
  logic w_pop;
  logic w_head;

  assign w_full = (r_count == CW'(DEPTH));

  // Controller selection. A lock pins the selection. Otherwise a single
  // requester wins, and a tie goes to the controller holding priority.
  always_comb begin
    w_sel = r_prio;
    if (r_lock) begin
      w_sel = r_lock_sel;
    end else if (c0_req_i && !c1_req_i) begin
      w_sel = 1'b0;
    end else if (!c0_req_i && c1_req_i) begin
      w_sel = 1'b1;
    end
  end

  assign w_req_sel = w_sel ? c1_req_i : c0_req_i;

  // Requests are blocked while full, even if a pop happens in the same
  // cycle. The freed slot becomes usable one cycle later.
  assign secondary_req_o   = w_req_sel && !w_full;
  assign secondary_addr_o  = w_sel ? c1_addr_i  : c0_addr_i;
  assign secondary_we_o    = w_sel ? c1_we_i    : c0_we_i;
  assign secondary_be_o    = w_sel ? c1_be_i    : c0_be_i;
  assign secondary_wdata_o = w_sel ? c1_wdata_i : c0_wdata_i;

  assign w_push   = secondary_req_o && secondary_gnt_i;
  assign c0_gnt_o = w_push && !w_sel;
  assign c1_gnt_o = w_push &&  w_sel;

  // Response routing. The FIFO head names the oldest issuer.
  assign w_pop       = secondary_rvalid_i && (r_count != '0);
  assign w_head      = r_fifo[r_rd_ptr];
  assign c0_rvalid_o = w_pop && !w_head;
  assign c1_rvalid_o = w_pop &&  w_head;
  assign c0_rdata_o  = secondary_rdata_i;
  assign c1_rdata_o  = secondary_rdata_i;

  assign outstanding_o = r_count;
  assign rsp_err_o     = r_rsp_err;

  // Next-state logic for the arbitration state
  always_comb begin
    r_prio_next     = r_prio;
    r_lock_next     = r_lock;
    r_lock_sel_next = r_lock_sel;
    if (w_push) begin
      r_prio_next = ~w_sel;
      r_lock_next = 1'b0;
    end else if (secondary_req_o) begin
      r_lock_next     = 1'b1;
      r_lock_sel_next = w_sel;
    end else if (r_lock && !w_req_sel) begin
      // The locked controller withdrew its request. Release the lock.
      r_lock_next = 1'b0;
    end
  end

  always_comb begin
    r_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   r_count_next = r_count + CW'(1);
      2'b01:   r_count_next = r_count - CW'(1);
      default: r_count_next = r_count;
    endcase
  end

  // State registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_prio     <= 1'b0;
      r_lock     <= 1'b0;
      r_lock_sel <= 1'b0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_rsp_err  <= 1'b0;
    end else begin
      r_prio     <= r_prio_next;
      r_lock     <= r_lock_next;
      r_lock_sel <= r_lock_sel_next;
      r_count    <= r_count_next;
      // DEPTH is a power of two, so the pointers wrap naturally.
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      if (secondary_rvalid_i && (r_count == '0)) r_rsp_err <= 1'b1;
    end
  end

  // ID FIFO storage, one flop per entry
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_fifo
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        r_fifo[gi] <= 1'b0;
      end else if (w_push && (r_wr_ptr == PW'(gi))) begin
        r_fifo[gi] <= w_sel;
      end
    end
  end

endmodule

// File: tb/tb_obi_arbiter_2to1.sv
module tb_obi_arbiter_2to1;

  localparam int DEPTH = 4;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b1;
  logic        c0_req_i = 1'b0, c1_req_i = 1'b0;
  logic        c0_gnt_o, c1_gnt_o;
  logic [31:0] c0_addr_i = '0, c1_addr_i = '0;
  logic        c0_we_i = 1'b0, c1_we_i = 1'b0;
  logic [3:0]  c0_be_i = 4'hF, c1_be_i = 4'hF;
  logic [31:0] c0_wdata_i = '0, c1_wdata_i = '0;
  logic        c0_rvalid_o, c1_rvalid_o;
  logic [31:0] c0_rdata_o, c1_rdata_o;
  logic        secondary_req_o;
  logic        secondary_gnt_i = 1'b0;
  logic [31:0] secondary_addr_o;
  logic        secondary_we_o;
  logic [3:0]  secondary_be_o;
  logic [31:0] secondary_wdata_o;
  logic        secondary_rvalid_i = 1'b0;
  logic [31:0] secondary_rdata_i = '0;
  logic [2:0]  outstanding_o;
  logic        rsp_err_o;

  int checks = 0;
  int errors = 0;
  bit exp_q[$];  // expected issuer ID of each outstanding transaction

  always #5 clk_i = ~clk_i;

  obi_arbiter_2to1 #(.DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .c0_req_i(c0_req_i), .c0_gnt_o(c0_gnt_o), .c0_addr_i(c0_addr_i),
    .c0_we_i(c0_we_i), .c0_be_i(c0_be_i), .c0_wdata_i(c0_wdata_i),
    .c0_rvalid_o(c0_rvalid_o), .c0_rdata_o(c0_rdata_o),
    .c1_req_i(c1_req_i), .c1_gnt_o(c1_gnt_o), .c1_addr_i(c1_addr_i),
    .c1_we_i(c1_we_i), .c1_be_i(c1_be_i), .c1_wdata_i(c1_wdata_i),
    .c1_rvalid_o(c1_rvalid_o), .c1_rdata_o(c1_rdata_o),
    .secondary_req_o(secondary_req_o), .secondary_gnt_i(secondary_gnt_i),
    .secondary_addr_o(secondary_addr_o), .secondary_we_o(secondary_we_o),
    .secondary_be_o(secondary_be_o), .secondary_wdata_o(secondary_wdata_o),
    .secondary_rvalid_i(secondary_rvalid_i), .secondary_rdata_i(secondary_rdata_i),
    .outstanding_o(outstanding_o), .rsp_err_o(rsp_err_o)
  );

  // Inputs change 1 time unit after the rising edge. Outputs are sampled on the falling edge.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    c0_req_i = 0; c1_req_i = 0; secondary_gnt_i = 0;
    secondary_rvalid_i = 0; secondary_rdata_i = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    @(negedge clk_i);
    rst_ni = 0;
    step();
    rst_ni = 1;
    exp_q.delete();
  endtask

  // Drive one response, pop the expected issuer, and check the routing.
  task automatic rsp_cycle(input logic [31:0] data);
    bit id;
    secondary_rvalid_i = 1; secondary_rdata_i = data;
    id = exp_q.pop_front();
    @(negedge clk_i);
    checks++;
    if (c0_rvalid_o !== !id || c1_rvalid_o !== id) begin
      errors++;
      $display("FAIL rsp_route: c0_rvalid=%b c1_rvalid=%b expected id %0d", c0_rvalid_o, c1_rvalid_o, id);
    end
    checks++;
    if ((id ? c1_rdata_o : c0_rdata_o) !== data) begin
      errors++;
      $display("FAIL rsp_data: got %h expected %h", id ? c1_rdata_o : c0_rdata_o, data);
    end
    $display("rsp  id=%0d data=%h c0_rvalid=%b c1_rvalid=%b", id, data, c0_rvalid_o, c1_rvalid_o);
    step();
    secondary_rvalid_i = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    @(negedge clk_i);
    rst_ni = 0;
    @(negedge clk_i);
    checks++;
    if ({secondary_req_o, c0_gnt_o, c1_gnt_o, c0_rvalid_o, c1_rvalid_o, rsp_err_o} !== 6'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 000000",
               {secondary_req_o, c0_gnt_o, c1_gnt_o, c0_rvalid_o, c1_rvalid_o, rsp_err_o});
    end
    checks++;
    if (outstanding_o !== 3'd0) begin
      errors++;
      $display("FAIL reset_outstanding: got %0d expected 0", outstanding_o);
    end
    step();
    rst_ni = 1;
    $display("reset done outstanding=%0d rsp_err=%b", outstanding_o, rsp_err_o);
  endtask

  task automatic test_single_read();
    do_reset();
    c0_req_i = 1; c0_addr_i = 32'h1000; secondary_gnt_i = 1;
    @(negedge clk_i);
    checks++;
    if (c0_gnt_o !== 1 || c1_gnt_o !== 0 || secondary_addr_o !== 32'h1000) begin
      errors++;
      $display("FAIL single_gnt: c0_gnt=%b c1_gnt=%b addr=%h expected 1 0 00001000", c0_gnt_o, c1_gnt_o, secondary_addr_o);
    end
    exp_q.push_back(0);
    $display("req  c0 addr=%h gnt=%b", secondary_addr_o, c0_gnt_o);
    step();
    c0_req_i = 0; secondary_gnt_i = 0;
    @(negedge clk_i);
    checks++;
    if (outstanding_o !== 3'd1) begin
      errors++;
      $display("FAIL single_outstanding: got %0d expected 1", outstanding_o);
    end
    step();
    rsp_cycle(32'hDEADBEEF);
    checks++;
    if (outstanding_o !== 3'd0) begin
      errors++;
      $display("FAIL single_drain: got %0d expected 0", outstanding_o);
    end
  endtask

  task automatic test_alternate();
    do_reset();
    c0_req_i = 1; c1_req_i = 1; c0_addr_i = 32'h100; c1_addr_i = 32'h200;
    secondary_gnt_i = 1;
    for (int i = 0; i < 4; i++) begin
      bit exp_id;
      exp_id = bit'(i % 2);
      @(negedge clk_i);
      checks++;
      if (c0_gnt_o !== !exp_id || c1_gnt_o !== exp_id ||
          secondary_addr_o !== (exp_id ? 32'h200 : 32'h100)) begin
        errors++;
        $display("FAIL alt_gnt%0d: c0_gnt=%b c1_gnt=%b addr=%h expected id %0d", i, c0_gnt_o, c1_gnt_o, secondary_addr_o, exp_id);
      end
      exp_q.push_back(exp_id);
      $display("req  alt %0d c0_gnt=%b c1_gnt=%b", i, c0_gnt_o, c1_gnt_o);
      step();
    end
    c0_req_i = 0; c1_req_i = 0; secondary_gnt_i = 0;
    for (int i = 0; i < 4; i++) rsp_cycle(32'hA000_0000 + i);
  endtask

  task automatic test_hold();
    do_reset();
    c0_req_i = 1; c1_req_i = 1; c0_addr_i = 32'hA0; c1_addr_i = 32'hB0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      checks++;
      if (secondary_addr_o !== 32'hA0 || secondary_req_o !== 1 || c0_gnt_o !== 0) begin
        errors++;
        $display("FAIL hold_stall%0d: addr=%h req=%b gnt=%b expected 000000a0 1 0", i, secondary_addr_o, secondary_req_o, c0_gnt_o);
      end
      step();
    end
    secondary_gnt_i = 1;
    @(negedge clk_i);
    checks++;
    if (c0_gnt_o !== 1 || c1_gnt_o !== 0) begin
      errors++;
      $display("FAIL hold_gnt_c0: c0_gnt=%b c1_gnt=%b expected 1 0", c0_gnt_o, c1_gnt_o);
    end
    exp_q.push_back(0);
    step();
    @(negedge clk_i);
    checks++;
    if (c1_gnt_o !== 1 || c0_gnt_o !== 0 || secondary_addr_o !== 32'hB0) begin
      errors++;
      $display("FAIL hold_gnt_c1: c0_gnt=%b c1_gnt=%b addr=%h expected 0 1 000000b0", c0_gnt_o, c1_gnt_o, secondary_addr_o);
    end
    exp_q.push_back(1);
    $display("req  hold granted c0 then c1");
    step();
    // Lock c1 with a stalled request. c0 then joins, and prio favours c0,
    // but the selection must stay on c1.
    c0_req_i = 0; c1_req_i = 1; secondary_gnt_i = 0;
    step();
    c0_req_i = 1;
    @(negedge clk_i);
    checks++;
    if (secondary_addr_o !== 32'hB0 || c0_gnt_o !== 0) begin
      errors++;
      $display("FAIL lock_hold: addr=%h c0_gnt=%b expected 000000b0 0", secondary_addr_o, c0_gnt_o);
    end
    step();
    secondary_gnt_i = 1;
    @(negedge clk_i);
    checks++;
    if (c1_gnt_o !== 1 || c0_gnt_o !== 0) begin
      errors++;
      $display("FAIL lock_gnt: c0_gnt=%b c1_gnt=%b expected 0 1", c0_gnt_o, c1_gnt_o);
    end
    exp_q.push_back(1);
    step();
    c0_req_i = 0; c1_req_i = 0; secondary_gnt_i = 0;
    for (int i = 0; i < 3; i++) rsp_cycle(32'hB000_0000 + i);
  endtask

  task automatic test_full();
    do_reset();
    c0_req_i = 1; c0_addr_i = 32'hC0; secondary_gnt_i = 1;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk_i);
      checks++;
      if (c0_gnt_o !== 1) begin
        errors++;
        $display("FAIL full_fill%0d: c0_gnt=%b expected 1", i, c0_gnt_o);
      end
      exp_q.push_back(0);
      step();
    end
    @(negedge clk_i);
    checks++;
    if (outstanding_o !== 3'd4 || secondary_req_o !== 0 || c0_gnt_o !== 0) begin
      errors++;
      $display("FAIL full_block: outstanding=%0d req=%b gnt=%b expected 4 0 0", outstanding_o, secondary_req_o, c0_gnt_o);
    end
    $display("full outstanding=%0d req=%b", outstanding_o, secondary_req_o);
    step();
    // A pop in a full cycle must not release the request in the same cycle.
    secondary_rvalid_i = 1; secondary_rdata_i = 32'hF0;
    void'(exp_q.pop_front());
    @(negedge clk_i);
    checks++;
    if (secondary_req_o !== 0 || c0_gnt_o !== 0 || c0_rvalid_o !== 1) begin
      errors++;
      $display("FAIL full_pop: req=%b gnt=%b rvalid=%b expected 0 0 1", secondary_req_o, c0_gnt_o, c0_rvalid_o);
    end
    step();
    secondary_rvalid_i = 0;
    @(negedge clk_i);
    checks++;
    if (outstanding_o !== 3'd3 || secondary_req_o !== 1 || c0_gnt_o !== 1) begin
      errors++;
      $display("FAIL full_reissue: outstanding=%0d req=%b gnt=%b expected 3 1 1", outstanding_o, secondary_req_o, c0_gnt_o);
    end
    $display("full reissue outstanding=%0d", outstanding_o);
    step();
    c0_req_i = 0; secondary_gnt_i = 0;
  endtask

  task automatic test_push_pop();
    do_reset();
    secondary_gnt_i = 1; c1_req_i = 1;
    exp_q.push_back(1);
    step();
    c1_req_i = 0; c0_req_i = 1;
    exp_q.push_back(0);
    step();
    // Grant and response in the same cycle at count 2
    secondary_rvalid_i = 1; secondary_rdata_i = 32'h5A5A;
    begin
      bit id;
      id = exp_q.pop_front();
      @(negedge clk_i);
      checks++;
      if (c0_gnt_o !== 1 || c1_rvalid_o !== id || c0_rvalid_o !== !id) begin
        errors++;
        $display("FAIL pushpop_same: gnt=%b c0_rvalid=%b c1_rvalid=%b expected 1 and id %0d", c0_gnt_o, c0_rvalid_o, c1_rvalid_o, id);
      end
    end
    exp_q.push_back(0);
    step();
    c0_req_i = 0; secondary_gnt_i = 0; secondary_rvalid_i = 0;
    @(negedge clk_i);
    checks++;
    if (outstanding_o !== 3'd2) begin
      errors++;
      $display("FAIL pushpop_count: got %0d expected 2", outstanding_o);
    end
    $display("pushpop outstanding=%0d", outstanding_o);
    step();
    rsp_cycle(32'h11);
    rsp_cycle(32'h22);
  endtask

  task automatic test_rsp_err();
    do_reset();
    secondary_rvalid_i = 1;
    @(negedge clk_i);
    checks++;
    if (c0_rvalid_o !== 0 || c1_rvalid_o !== 0 || rsp_err_o !== 0) begin
      errors++;
      $display("FAIL err_pulse: c0_rvalid=%b c1_rvalid=%b err=%b expected 0 0 0", c0_rvalid_o, c1_rvalid_o, rsp_err_o);
    end
    step();
    secondary_rvalid_i = 0;
    @(negedge clk_i);
    checks++;
    if (rsp_err_o !== 1) begin
      errors++;
      $display("FAIL err_set: got %b expected 1", rsp_err_o);
    end
    #2 rst_ni = 0;
    #1;
    checks++;
    if (rsp_err_o !== 0) begin
      errors++;
      $display("FAIL err_async_clear: got %b expected 0", rsp_err_o);
    end
    $display("rsp_err cleared asynchronously err=%b", rsp_err_o);
    step();
    rst_ni = 1;
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_alternate();
    test_hold();
    test_full();
    test_push_pop();
    test_rsp_err();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
